// File: rtl/udp_tx_arb_pkg.sv
// Shared definitions for the two-channel UDP transmit arbiter.
//   state_t          : arbiter FSM states
//   UDP_MAX_PAYLOAD  : largest UDP payload in one Ethernet frame (bytes)
//   ARB_CH           : number of arbitrated channels
package udp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    GAP
  } state_t;

  localparam int unsigned UDP_MAX_PAYLOAD = 1472;
  localparam int unsigned ARB_CH          = 2;

endpackage

// File: rtl/udp_tx_arb_if.sv
// Link between the arbiter and the shared udp_tx/CRC transmit path.
//   tx_start_en : arbiter -> path, one-cycle frame start
//   tx_byte_num : arbiter -> path, payload byte count of the frame
//   tx_data     : arbiter -> path, payload word of the granted channel
//   tx_req      : path -> arbiter, word request
//   tx_done     : path -> arbiter, frame-complete pulse
// master = arbiter side, slave = transmit path side.
interface udp_tx_arb_if;

  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic        tx_req;
  logic        tx_done;

  modport master (
    output tx_start_en,
    output tx_byte_num,
    output tx_data,
    input  tx_req,
    input  tx_done
  );

  modport slave (
    input  tx_start_en,
    input  tx_byte_num,
    input  tx_data,
    output tx_req,
    output tx_done
  );

endinterface

// File: rtl/udp_tx_arb_rr_pick2.sv
// Combinational two-way round-robin select.
//   req   : request vector, bit n = channel n
//   last  : channel granted most recently
//   win   : selected channel (meaningful only when valid)
//   valid : at least one request present
module rr_pick2
  import udp_arb_pkg::*;
(
  input  logic [ARB_CH-1:0] req,
  input  logic              last,
  output logic              win,
  output logic              valid
);

  always_comb begin
    valid = |req;
    // Contention goes to the channel that did not win last time.
    win   = (req[0] && req[1]) ? ~last : req[1];
  end

endmodule

// File: rtl/udp_tx_arb.sv
// Two-channel arbiter/sequencer sharing one UDP transmit path between two
// camera packetizers: round-robin grant, start pulse with byte count,
// word steering while sending, completion ack, then an inter-packet gap.
//   clk, rst            : transmit clock, synchronous active-high reset
//   req0/1, byte_num0/1 : per-channel packet request and payload size
//   data0/1, rd_en0/1   : per-channel FIFO read data and read enable
//   ack0/1, err         : completion pulse per channel, error qualifier
//   tx                  : transmit path link (start, size, data, req, done)
//   grant, busy         : current/last granted channel, not-idle flag
module udp_tx_arb
  import udp_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 12,
  parameter int unsigned MAX_BYTES  = UDP_MAX_PAYLOAD,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [15:0]         byte_num0,
  input  logic [15:0]         byte_num1,
  input  logic [31:0]         data0,
  input  logic [31:0]         data1,
  output logic                rd_en0,
  output logic                rd_en1,
  output logic                ack0,
  output logic                ack1,
  output logic                err,
  udp_tx_arb_if.master        tx,
  output logic                grant,
  output logic                busy
);

  state_t      state, state_nx;
  logic [15:0] to_cnt, to_cnt_nx;
  logic [7:0]  gap_cnt, gap_cnt_nx;
  logic        grant_q, grant_nx;
  logic        last_q, last_nx;
  logic [15:0] bytes_q, bytes_nx;
  logic [1:0]  ack_q, ack_nx;
  logic        err_q, err_nx;

  logic        pick_win;
  logic        pick_valid;
  logic [15:0] pick_bytes;
  logic        pick_ok;

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (last_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    pick_bytes = pick_win ? byte_num1 : byte_num0;
    pick_ok    = (pick_bytes != 16'd0) && (32'(pick_bytes) <= MAX_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      to_cnt  <= '0;
      gap_cnt <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      bytes_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      to_cnt  <= to_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      grant_q <= grant_nx;
      last_q  <= last_nx;
      bytes_q <= bytes_nx;
      ack_q   <= ack_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    to_cnt_nx  = to_cnt;
    gap_cnt_nx = gap_cnt;
    grant_nx   = grant_q;
    last_nx    = last_q;
    bytes_nx   = bytes_q;
    ack_nx     = '0;
    err_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nx = pick_win;
          last_nx  = pick_win;
          bytes_nx = pick_bytes;
          if (pick_ok) begin
            state_nx = START;
          end else begin
            // Rejected packet still completes the handshake so the
            // requester can drop its request.
            state_nx         = GAP;
            gap_cnt_nx       = GAP_CYCLES[7:0];
            ack_nx[pick_win] = 1'b1;
            err_nx           = 1'b1;
          end
        end
      end
      START: begin
        to_cnt_nx = '0;
        state_nx  = SEND;
      end
      SEND: begin
        to_cnt_nx = to_cnt + 16'd1;
        // tx_done wins over a timeout landing in the same cycle.
        if (tx.tx_done) begin
          state_nx        = GAP;
          gap_cnt_nx      = GAP_CYCLES[7:0];
          ack_nx[grant_q] = 1'b1;
        end else if (32'(to_cnt) == TIMEOUT - 32'd1) begin
          state_nx        = GAP;
          gap_cnt_nx      = GAP_CYCLES[7:0];
          ack_nx[grant_q] = 1'b1;
          err_nx          = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt <= 8'd1) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx.tx_start_en = (state == START);
  assign tx.tx_byte_num = bytes_q;
  assign tx.tx_data     = grant_q ? data1 : data0;

  assign rd_en0 = tx.tx_req && (state == SEND) && !grant_q;
  assign rd_en1 = tx.tx_req && (state == SEND) &&  grant_q;

  assign ack0  = ack_q[0];
  assign ack1  = ack_q[1];
  assign err   = err_q;
  assign grant = grant_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_udp_tx_arb.sv
module tb_udp_tx_arb;

  localparam int unsigned GAP     = 12;
  localparam int unsigned MAXB    = 1472;
  localparam int unsigned TIMEOUT = 100;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [15:0] byte_num0, byte_num1;
  logic [31:0] data0, data1;
  logic        rd_en0, rd_en1, ack0, ack1, err, grant, busy;

  udp_tx_arb_if tx_if ();

  udp_tx_arb #(
    .GAP_CYCLES (GAP),
    .MAX_BYTES  (MAXB),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .byte_num0 (byte_num0),
    .byte_num1 (byte_num1),
    .data0     (data0),
    .data1     (data1),
    .rd_en0    (rd_en0),
    .rd_en1    (rd_en1),
    .ack0      (ack0),
    .ack1      (ack1),
    .err       (err),
    .tx        (tx_if),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        r0, r1;
    logic [15:0] b0, b1;
    int unsigned delay;
    logic        exp_ch;
    logic [15:0] exp_bytes;
    logic        exp_start;
    logic        exp_err;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    byte_num0 = '0; byte_num1 = '0;
    data0 = '0; data1 = '0;
    tx_if.tx_req = 1'b0; tx_if.tx_done = 1'b0;
    tick(); tick(); settle();
    chk("reset_vals",
        {tx_if.tx_start_en, ack0, ack1, err, busy, grant, rd_en0, rd_en1, tx_if.tx_byte_num},
        '0);
    rst = 1'b0;
  endtask

  // One complete transaction starting from IDLE, ending at the first IDLE cycle.
  task automatic run_txn(input vec_t v);
    int unsigned n;
    req0 = v.r0; req1 = v.r1; byte_num0 = v.b0; byte_num1 = v.b1;
    tx_if.tx_req = 1'b1; tx_if.tx_done = 1'b1;
    settle();
    chk("idle_quiet", {busy, rd_en0, rd_en1, ack0, ack1, err, tx_if.tx_start_en}, '0);
    tick();
    tx_if.tx_req = 1'b0; tx_if.tx_done = 1'b0;
    settle();
    chk("grant", {grant, tx_if.tx_byte_num}, {v.exp_ch, v.exp_bytes});
    chk("start", {tx_if.tx_start_en, busy}, {v.exp_start, 1'b1});
    if (v.exp_start) begin
      chk("start_noack", {ack0, ack1, err}, '0);
      for (int unsigned s = 0; s < TIMEOUT; s++) begin
        tick();
        data0 = $urandom; data1 = $urandom;
        tx_if.tx_req  = 1'($urandom % 2);
        tx_if.tx_done = (s == v.delay);
        settle();
        chk("send",
            {tx_if.tx_start_en, ack0, ack1, err, busy, rd_en0, rd_en1, tx_if.tx_data},
            {5'b00001, tx_if.tx_req && !v.exp_ch, tx_if.tx_req && v.exp_ch,
             (v.exp_ch ? data1 : data0)});
        if (tx_if.tx_done) break;
      end
      tick();
    end
    tx_if.tx_req = 1'b0; tx_if.tx_done = 1'b0;
    settle();
    chk("ack", {ack0, ack1, err, busy, tx_if.tx_start_en}, {!v.exp_ch, v.exp_ch, v.exp_err, 2'b10});
    req0 = 1'b0; req1 = 1'b0;
    n = 1;
    while (n < 64) begin
      tick();
      tx_if.tx_req  = 1'($urandom % 2);
      tx_if.tx_done = 1'($urandom % 2);
      settle();
      chk("gap_quiet", {ack0, ack1, err, rd_en0, rd_en1, tx_if.tx_start_en}, '0);
      if (!busy) break;
      n++;
    end
    chk("gap_len", 64'(n), 64'(GAP));
    tx_if.tx_req = 1'b0; tx_if.tx_done = 1'b0;
  endtask

  // Reset while channel ch is sending, then check channel 0 wins a contest.
  task automatic reset_in_send(input logic ch);
    req0 = !ch; req1 = ch; byte_num0 = 16'd100; byte_num1 = 16'd100;
    tick(); tick();
    tx_if.tx_req = 1'b1;
    settle();
    chk("rs_send_rd", {rd_en0, rd_en1, busy, grant}, {!ch, ch, 1'b1, ch});
    rst = 1'b1;
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    settle();
    chk("rs_after",
        {busy, grant, tx_if.tx_byte_num, tx_if.tx_start_en, rd_en0, rd_en1, ack0, ack1, err},
        '0);
    req0 = 1'b1; req1 = 1'b1; byte_num0 = 16'd20; byte_num1 = 16'd30;
    tx_if.tx_req = 1'b0;
    tick(); settle();
    chk("rs_regrant", {grant, tx_if.tx_byte_num, tx_if.tx_start_en}, {1'b0, 16'd20, 1'b1});
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
  endtask

  // Randomised run against a timeline model of the arbiter.
  task automatic run_random(input int cycles);
    int          m_free, m_gcyc, m_start, m_sfrom, m_slast, m_ack, m_done;
    logic        m_grant, m_last, m_err, w, in_win;
    logic [15:0] m_bytes;
    logic [15:0] bn [2];
    logic        rq [2];
    logic        drop [2];
    logic        ae [2];
    int unsigned k, r;
    logic [63:0] got, exp;
    m_free = 0; m_gcyc = -1000; m_start = -1000; m_sfrom = 1; m_slast = 0;
    m_ack = -1000; m_done = -1000;
    m_grant = 1'b0; m_last = 1'b1; m_err = 1'b0; m_bytes = '0;
    for (int i = 0; i < 2; i++) begin bn[i] = '0; rq[i] = 1'b0; drop[i] = 1'b0; end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (drop[i]) begin
          rq[i] = 1'b0; drop[i] = 1'b0;
        end else if (!rq[i] && ($urandom % 6 == 0)) begin
          rq[i] = 1'b1;
          r = $urandom % 10;
          if (r == 0)      bn[i] = 16'd0;
          else if (r == 1) bn[i] = 16'(MAXB + 1 + $urandom % 100);
          else if (r == 2) bn[i] = 16'(MAXB);
          else             bn[i] = 16'(1 + $urandom % MAXB);
        end
      end
      req0 = rq[0]; req1 = rq[1]; byte_num0 = bn[0]; byte_num1 = bn[1];
      data0 = $urandom; data1 = $urandom;
      in_win = (c >= m_sfrom) && (c <= m_slast);
      tx_if.tx_req  = 1'($urandom % 2);
      tx_if.tx_done = in_win ? (c == m_done) : ($urandom % 10 == 0);
      settle();
      ae[0] = (c == m_ack) && !m_grant;
      ae[1] = (c == m_ack) &&  m_grant;
      exp = {8'h0, (c == m_start), ae[0], ae[1], (c == m_ack) && m_err,
             (c > m_gcyc) && (c < m_free), m_grant,
             tx_if.tx_req && in_win && !m_grant, tx_if.tx_req && in_win && m_grant,
             m_bytes, (m_grant ? data1 : data0)};
      got = {8'h0, tx_if.tx_start_en, ack0, ack1, err, busy, grant, rd_en0, rd_en1,
             tx_if.tx_byte_num, tx_if.tx_data};
      chk("rand_cycle", got, exp);
      for (int i = 0; i < 2; i++) if (ae[i]) drop[i] = 1'b1;
      if ((c >= m_free) && (rq[0] || rq[1])) begin
        w = (rq[0] && rq[1]) ? !m_last : rq[1];
        m_last = w; m_grant = w; m_bytes = bn[w]; m_gcyc = c;
        if (bn[w] == 0 || bn[w] > MAXB) begin
          m_start = -1000; m_sfrom = 1; m_slast = 0;
          m_ack = c + 1; m_err = 1'b1;
        end else begin
          m_start = c + 1; m_sfrom = c + 2;
          r = $urandom % 16;
          if (r == 0)      k = TIMEOUT + $urandom % 20;
          else if (r == 1) k = TIMEOUT - 1;
          else             k = $urandom % 30;
          m_done = m_sfrom + int'(k);
          if (k >= TIMEOUT) begin
            m_ack = m_sfrom + int'(TIMEOUT); m_err = 1'b1;
          end else begin
            m_ack = m_done + 1; m_err = 1'b0;
          end
          m_slast = m_ack - 1;
        end
        m_free = m_ack + int'(GAP);
      end
      tick();
    end
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 16'd256,  16'd512,  3,   1'b0, 16'd256,  1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 16'd256,  16'd512,  0,   1'b1, 16'd512,  1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 16'd256,  16'd512,  7,   1'b0, 16'd256,  1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 16'd0,    16'd1472, 5,   1'b1, 16'd1472, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 16'd0,    16'd9,    0,   1'b0, 16'd0,    1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 16'd1473, 16'd9,    0,   1'b0, 16'd1473, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 16'd1,    16'd1,    2,   1'b1, 16'd1,    1'b1, 1'b0};
    vt[7] = '{1'b0, 1'b1, 16'd5,    16'd2000, 0,   1'b1, 16'd2000, 1'b0, 1'b1};
    vt[8] = '{1'b1, 1'b1, 16'd64,   16'd64,   150, 1'b0, 16'd64,   1'b1, 1'b1};
    vt[9] = '{1'b1, 1'b1, 16'd1472, 16'd10,   99,  1'b1, 16'd10,   1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) run_txn(vt[i]);

    do_reset();
    reset_in_send(1'b1);
    reset_in_send(1'b0);

    do_reset();
    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
